// File: rtl/hex_display_scan_if.sv
// Bus between a datapath and the scanned hex display: shadow-load controls in,
// multiplexed segment / anode / scan-index pins out.
interface hex_display_scan_if #(
  parameter int DIGITS = 4
);
  logic                          Load;
  logic [4*DIGITS-1:0]           Value;
  logic                          LzEn;
  logic [DIGITS-1:0]             BlinkMask;
  logic                          Blank;
  logic [0:6]                    Seg;
  logic [DIGITS-1:0]             Anode;
  logic [$clog2(DIGITS)-1:0]     Scan;

  modport master (
    output Load, Value, LzEn, BlinkMask, Blank,
    input  Seg, Anode, Scan
  );

  modport slave (
    input  Load, Value, LzEn, BlinkMask, Blank,
    output Seg, Anode, Scan
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed DIGITS-wide hex display driver with shadow-latched value,
// leading-zero suppression, per-digit blink and global blanking.
module hex_display_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input logic               Clock,
  input logic               Reset,
  hex_display_scan_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [SW-1:0]       divCount_q, divCount_d;
  logic [IW-1:0]       index_q, index_d;
  logic [BW-1:0]       blinkCount_q, blinkCount_d;
  logic                blinkPhase_q, blinkPhase_d;
  logic [4*DIGITS-1:0] shadowValue_q, shadowValue_d;
  logic                shadowLz_q, shadowLz_d;
  logic [DIGITS-1:0]   shadowBlink_q, shadowBlink_d;
  logic [0:6]          seg_q, seg_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [IW-1:0]       scan_q, scan_d;

  logic [DIGITS-1:0]   lzMask;
  logic                zeroAbove;
  logic [3:0]          nibble;
  logic                blankDigit;

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0001100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    divCount_d   = divCount_q + 1'b1;
    index_d      = index_q;
    if (divCount_q == SW'(SCAN_DIV - 1)) begin
      divCount_d = '0;
      index_d    = (index_q == IW'(DIGITS - 1)) ? '0 : index_q + 1'b1;
    end
    blinkCount_d = blinkCount_q + 1'b1;
    blinkPhase_d = blinkPhase_q;
    if (blinkCount_q == BW'(BLINK_DIV - 1)) begin
      blinkCount_d = '0;
      blinkPhase_d = ~blinkPhase_q;
    end
    shadowValue_d = shadowValue_q;
    shadowLz_d    = shadowLz_q;
    shadowBlink_d = shadowBlink_q;
    if (bus.Load) begin
      shadowValue_d = bus.Value;
      shadowLz_d    = bus.LzEn;
      shadowBlink_d = bus.BlinkMask;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero; digit 0 never is.
  always_comb begin
    zeroAbove = 1'b1;
    lzMask    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zeroAbove = zeroAbove && (shadowValue_q[4*k +: 4] == 4'h0);
      lzMask[k] = zeroAbove && (k != 0);
    end
  end

  always_comb begin
    nibble     = shadowValue_q[4*index_q +: 4];
    blankDigit = (shadowLz_q && lzMask[index_q]) || (shadowBlink_q[index_q] && blinkPhase_q);
    seg_d      = blankDigit ? 7'b1111111 : glyph(nibble);
    anode_d    = ~(DIGITS'(1) << index_q);
    scan_d     = index_q;
    if (bus.Blank) begin
      seg_d   = 7'b1111111;
      anode_d = '1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      divCount_q    <= '0;
      index_q       <= '0;
      blinkCount_q  <= '0;
      blinkPhase_q  <= 1'b0;
      shadowValue_q <= '0;
      shadowLz_q    <= 1'b0;
      shadowBlink_q <= '0;
      seg_q         <= 7'b1111111;
      anode_q       <= '1;
      scan_q        <= '0;
    end else begin
      divCount_q    <= divCount_d;
      index_q       <= index_d;
      blinkCount_q  <= blinkCount_d;
      blinkPhase_q  <= blinkPhase_d;
      shadowValue_q <= shadowValue_d;
      shadowLz_q    <= shadowLz_d;
      shadowBlink_q <= shadowBlink_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
      scan_q        <= scan_d;
    end
  end

  assign bus.Seg   = seg_q;
  assign bus.Anode = anode_q;
  assign bus.Scan  = scan_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: directed scenarios plus random loads/blanks/resets,
// compared every cycle against an arithmetic model of the scanned display.
module tb_hex_display_scan;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic Clock = 1'b0;
  logic Reset;

  hex_display_scan_if #(.DIGITS(DIGITS)) bus ();

  hex_display_scan #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyphTab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: position in the scan and blink cycle comes purely from
  // the number of edges elapsed since the last reset.
  int                  edgeCount = 0;
  logic [4*DIGITS-1:0] mVal   = '0;
  logic                mLz    = 1'b0;
  logic [DIGITS-1:0]   mBlink = '0;
  logic [6:0]          expSeg;
  logic [DIGITS-1:0]   expAnode;
  logic [1:0]          expScan;

  always @(posedge Clock) begin
    int idx;
    int phase;
    logic [4*DIGITS-1:0] upper;
    if (Reset) begin
      expSeg    = 7'b1111111;
      expAnode  = '1;
      expScan   = '0;
      mVal      = '0;
      mLz       = 1'b0;
      mBlink    = '0;
      edgeCount = 0;
    end else begin
      idx   = (edgeCount / SCAN_DIV) % DIGITS;
      phase = (edgeCount / BLINK_DIV) % 2;
      upper = mVal >> (4 * idx);
      expScan = idx[1:0];
      if (bus.Blank) begin
        expSeg   = 7'b1111111;
        expAnode = '1;
      end else begin
        expAnode = ~(DIGITS'(1) << idx);
        if ((mLz && idx != 0 && upper == '0) || (mBlink[idx] && phase == 1))
          expSeg = 7'b1111111;
        else
          expSeg = glyphTab[upper[3:0]];
      end
      if (bus.Load) begin
        mVal   = bus.Value;
        mLz    = bus.LzEn;
        mBlink = bus.BlinkMask;
      end
      edgeCount++;
    end
  end

  task automatic applyStimulus(input logic rst, input logic load,
                               input logic [4*DIGITS-1:0] value, input logic lz,
                               input logic [DIGITS-1:0] mask, input logic blank);
    Reset         = rst;
    bus.Load      = load;
    bus.Value     = value;
    bus.LzEn      = lz;
    bus.BlinkMask = mask;
    bus.Blank     = blank;
  endtask

  task automatic checkOutput();
    checks++;
    assert (bus.Seg === expSeg) else begin
      errors++;
      $error("[TB] FAIL seg t=%0t observed=%b expected=%b", $time, bus.Seg, expSeg);
    end
    checks++;
    assert (bus.Anode === expAnode) else begin
      errors++;
      $error("[TB] FAIL anode t=%0t observed=%b expected=%b", $time, bus.Anode, expAnode);
    end
    checks++;
    assert (bus.Scan === expScan) else begin
      errors++;
      $error("[TB] FAIL scan t=%0t observed=%0d expected=%0d", $time, bus.Scan, expScan);
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkOutput();
    end
  endtask

  // Directed spec-constant check independent of the model.
  task automatic checkConst(input string tag, input logic [6:0] seg, input logic [DIGITS-1:0] an);
    checks++;
    assert (bus.Seg === seg && bus.Anode === an) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b/%b expected=%b/%b", tag, bus.Seg, bus.Anode, seg, an);
    end
  endtask

  initial begin
    // Reset with a simultaneous Load: the shadow must stay zero.
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1, 4'hF, 1'b0);
    runCycles(2);
    checkConst("reset_outputs", 7'b1111111, 4'b1111);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(2);
    checkConst("first_lit_zero", 7'b0000001, 4'b1110);
    runCycles(18);

    $display("[TB] scan timing 1234");
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 4'h0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(40);

    $display("[TB] glyph sweep");
    foreach (glyphTab[k]) begin
      if (k % 4 == 0) begin
        applyStimulus(1'b0, 1'b1, 16'h0123 + 16'(k/4) * 16'h4444, 1'b0, 4'h0, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
        runCycles(16);
      end
    end

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b0, 1'b1, 16'h0050, 1'b1, 4'h0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(16);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(16);

    $display("[TB] blink and blank");
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 4'b0001, 1'b0);
    runCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(64);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1);
    runCycles(1);
    checkConst("blank_anode", 7'b1111111, 4'b1111);
    runCycles(4);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0);
    runCycles(20);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                    16'($urandom), 1'($urandom), 4'($urandom),
                    $urandom_range(0, 9) == 0);
      runCycles(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
